// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//
// Purpose:
//    Push-button front end for the game logic. For each channel it
//    synchronises the raw pin, debounces it, emits one-cycle press and release
//    pulses, and emits a "move" pulse stream. A held key gives its press pulse
//    and then, after a delay, auto-repeat pulses at a fixed period.
//
// Ports:
//    CLK25M       in   1        system clock, rising edge
//    Reset        in   1        asynchronous, active-high reset
//    btn_raw      in   N_BTN    raw asynchronous button pins
//    btn_level    out  N_BTN    debounced level
//    btn_press    out  N_BTN    one-cycle pulse on a debounced rising edge
//    btn_release  out  N_BTN    one-cycle pulse on a debounced falling edge
//    btn_move     out  N_BTN    press pulse plus auto-repeat pulses
//    o_dbg_state  out  2*N_BTN  repeat FSM state per channel, 2 bits each
//                               (0 = IDLE, 1 = DELAY, 2 = REPEAT)
//
// Handshake: none. Every output is a registered level or a one-cycle pulse.
// No output has a valid/ready pair, and no output needs an acknowledge.
// -----------------------------------------------------------------------------
module btn_conditioner #(
   parameter int               N_BTN           = 4,
   parameter int               DEBOUNCE_CYCLES = 250000,
   parameter int               REPEAT_DELAY    = 5000000,
   parameter int               REPEAT_PERIOD   = 1250000,
   parameter logic [N_BTN-1:0] REPEAT_MASK     = N_BTN'(4'b0111)
) (
   input  logic                 CLK25M,
   input  logic                 Reset,
   input  logic [N_BTN-1:0]     btn_raw,
   output logic [N_BTN-1:0]     btn_level,
   output logic [N_BTN-1:0]     btn_press,
   output logic [N_BTN-1:0]     btn_release,
   output logic [N_BTN-1:0]     btn_move,
   output logic [2*N_BTN-1:0]   o_dbg_state
);

   localparam int CW   = $clog2(DEBOUNCE_CYCLES);
   localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int TW   = $clog2(TMAX);

   localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] TIMER_DLY = TW'(REPEAT_DELAY - 1);
   localparam logic [TW-1:0] TIMER_PER = TW'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_REPEAT = 2'd2
   } state_t;

   for (genvar g = 0; g < N_BTN; g++) begin : g_ch
      logic          r_s1;
      logic          r_s2;
      logic [CW-1:0] r_cnt;
      logic          r_level;
      logic          r_press;
      logic          r_release;
      logic          r_move;
      state_t        r_state;
      logic [TW-1:0] r_timer;
      state_t        w_state_nxt;
      logic [TW-1:0] w_timer_nxt;
      logic          w_move_nxt;
      logic          w_accept;
      logic          w_press_evt;
      logic          w_release_evt;

      // The level is accepted when the mismatch survives the final count.
      // The edge direction follows from the level that is being replaced.
      assign w_accept      = (r_s2 != r_level) && (r_cnt == CNT_LAST);
      assign w_press_evt   = w_accept && !r_level;
      assign w_release_evt = w_accept &&  r_level;

      // Synchroniser, debouncer, and the press/release pulse registers.
      always_ff @(posedge CLK25M or posedge Reset) begin
         if (Reset) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
         end else begin
            r_s1      <= btn_raw[g];
            r_s2      <= r_s1;
            r_press   <= w_press_evt;
            r_release <= w_release_evt;
            if (r_s2 == r_level) begin
               r_cnt <= '0;
            end else if (w_accept) begin
               r_level <= ~r_level;
               r_cnt   <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end

      // Repeat FSM: state register
      always_ff @(posedge CLK25M or posedge Reset) begin
         if (Reset) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_move  <= 1'b0;
         end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_move  <= w_move_nxt;
         end
      end

      // Repeat FSM: next state and timer.
      // A release beats a timer expiry on the same edge, so the pending
      // repeat pulse is dropped.
      always_comb begin
         w_state_nxt = r_state;
         w_timer_nxt = r_timer;
         case (r_state)
            ST_IDLE: begin
               if (w_press_evt && REPEAT_MASK[g]) begin
                  w_state_nxt = ST_DELAY;
                  w_timer_nxt = TIMER_DLY;
               end
            end
            ST_DELAY, ST_REPEAT: begin
               if (w_release_evt) begin
                  w_state_nxt = ST_IDLE;
                  w_timer_nxt = '0;
               end else if (r_timer == '0) begin
                  w_state_nxt = ST_REPEAT;
                  w_timer_nxt = TIMER_PER;
               end else begin
                  w_timer_nxt = r_timer - 1'b1;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_timer_nxt = '0;
            end
         endcase
      end

      // Repeat FSM: move pulse (registered in the state-register process)
      always_comb begin
         w_move_nxt = 1'b0;
         case (r_state)
            ST_IDLE:             w_move_nxt = w_press_evt;
            ST_DELAY, ST_REPEAT: w_move_nxt = !w_release_evt && (r_timer == '0);
            default:             w_move_nxt = 1'b0;
         endcase
      end

      assign btn_level[g]          = r_level;
      assign btn_press[g]          = r_press;
      assign btn_release[g]        = r_release;
      assign btn_move[g]           = r_move;
      assign o_dbg_state[2*g +: 2] = r_state;
   end

endmodule
